bus_io_bridge: RTL and testbench

Memory-side bridge sitting directly downstream of the single-cycle CPU's external bus: it consumes `a_bus`, `d_bus_2` and `c_bus`, and produces `d_bus_1`. It contains a 64-word data RAM, a buffered output port (FIFO with valid/ready drain) and a single-entry input holding register (valid/ready fill), all memory-mapped. Reads are combinational so that a load completes in the CPU's single cycle; writes and read side effects commit on the clock edge.

---
 rtl/bus_io_bridge_pkg.sv | 49 ++++
 rtl/bus_io_bridge_if.sv | 60 ++++++
 rtl/bus_io_bridge_out_fifo.sv | 83 ++++++++
 rtl/bus_io_bridge.sv | 177 +++++++++++++++++
 tb/tb_bus_io_bridge.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_io_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared definitions for the memory-side bus bridge: CPU
//                command encodings, the I/O page number, I/O register
//                offsets, d_bus_1 status bit positions and small decode
//                helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    // CPU command on c_bus. 2'b11 is reserved and treated as idle.
    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    // a_bus[15:8] value that selects the I/O register page.
    localparam logic [7:0] c_io_page = 8'hFF;

    // I/O register offsets within the page (a_bus[7:0], word aligned).
    localparam logic [7:0] c_off_out_data = 8'h00;
    localparam logic [7:0] c_off_out_stat = 8'h04;
    localparam logic [7:0] c_off_in_data  = 8'h08;
    localparam logic [7:0] c_off_in_stat  = 8'h0C;

    // Status bits carried on d_bus_1 above the 32-bit read data.
    localparam int c_d1_hold_bit = 32;
    localparam int c_d1_full_bit = 33;

    // True when the byte address falls in the I/O page.
    function automatic logic is_io_page(input logic [31:0] addr);
        return addr[15:8] == c_io_page;
    endfunction

    // Word-aligned register offset; the byte-lane bits are don't-care.
    function automatic logic [7:0] io_offset(input logic [31:0] addr);
        return {addr[7:2], 2'b00};
    endfunction

    // OUT_STAT layout: sticky overflow in the MSB, FIFO count in the LSBs.
    function automatic logic [31:0] out_stat_word(input logic ovf, input logic [3:0] cnt);
        return {ovf, 27'b0, cnt};
    endfunction

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_io_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_io_bridge_if
//  Description : Bundle of the CPU external bus plus the external input and
//                output streaming ports of the bus bridge.
//  Ports (signals):
//      a_bus     [31:0]  CPU byte address
//      d_bus_2   [31:0]  CPU write data
//      c_bus     [1:0]   CPU command (idle/read/write)
//      d_bus_1   [33:0]  read data + {out full, in hold valid}
//      in_data   [31:0]  external input word
//      in_valid          external input offered
//      in_ready          holding register empty
//      out_data  [31:0]  output FIFO head
//      out_valid         output FIFO non-empty
//      out_ready         external consumer accepts the head
//  Modports: master (CPU / environment side), slave (bridge side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_io_bridge_if;

    logic [31:0] a_bus;
    logic [31:0] d_bus_2;
    logic [1:0]  c_bus;
    logic [33:0] d_bus_1;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output a_bus,
        output d_bus_2,
        output c_bus,
        output in_data,
        output in_valid,
        output out_ready,
        input  d_bus_1,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  a_bus,
        input  d_bus_2,
        input  c_bus,
        input  in_data,
        input  in_valid,
        input  out_ready,
        output d_bus_1,
        output in_ready,
        output out_data,
        output out_valid
    );

endinterface : bus_io_bridge_if
`default_nettype wire

// File: rtl/bus_io_bridge_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : io_out_fifo
//  Description : Output-port FIFO of the bus bridge. A push is taken when
//                there is room, or when the FIFO is full but the head is
//                leaving in the same cycle. A pop request on an empty FIFO
//                is ignored. Storage is not reset; only pointers and count.
//  Ports:
//      clk, rst          clock, asynchronous active-high reset
//      i_push            push request
//      i_push_data       word to push
//      i_pop             pop request (consumer ready)
//      o_count           number of stored words, 0..DEPTH
//      o_full, o_empty   occupancy flags
//      o_head            oldest word (undefined while empty)
//  Revision    : 1.0 - initial release
// ============================================================================
module io_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Pop only when something is there; a full FIFO that pops frees the
    // slot the simultaneous push needs, so count holds at DEPTH.
    assign w_pop  = i_pop & ~w_empty;
    assign w_push = i_push & (~w_full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Data storage carries no reset; stale words are hidden by the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_head  = r_mem[r_rd_ptr];

endmodule : io_out_fifo
`default_nettype wire

// File: rtl/bus_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : bus_io_bridge
//  Description : Memory-side bridge on the single-cycle CPU's external bus.
//                Decodes a_bus into a data RAM or an I/O page holding an
//                output FIFO (valid/ready drain) and a single-entry input
//                holding register (valid/ready fill). Reads are
//                combinational so a load completes in the CPU's cycle;
//                writes and read side effects (input pop) commit at the edge.
//  Ports:
//      clk           system clock shared with the CPU
//      rst           asynchronous active-high reset
//      bus (slave)   a_bus/d_bus_2/c_bus in, d_bus_1 out,
//                    in_data/in_valid in, in_ready out,
//                    out_data/out_valid out, out_ready in
//  Parameters:
//      OUT_DEPTH     output FIFO depth (power of two, >= 2)
//      RAM_WORDS     data RAM words, indexed by a_bus[7:2]
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_io_bridge
    import bus_pkg::*;
#(
    parameter int OUT_DEPTH = 4,
    parameter int RAM_WORDS = 64
) (
    input  logic           clk,
    input  logic           rst,
    bus_io_bridge_if.slave bus
);

    localparam int c_ram_aw = $clog2(RAM_WORDS);
    localparam int c_cnt_w  = $clog2(OUT_DEPTH + 1);

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic                w_rd;
    logic                w_wr;
    logic                w_io;
    logic [7:0]          w_off;
    logic [c_ram_aw-1:0] w_ram_idx;

    assign w_rd      = (bus.c_bus == CMD_READ);
    assign w_wr      = (bus.c_bus == CMD_WRITE);
    assign w_io      = is_io_page(bus.a_bus);
    assign w_off     = io_offset(bus.a_bus);
    assign w_ram_idx = bus.a_bus[2 +: c_ram_aw];

    logic w_ram_wr;
    logic w_push;
    logic w_stat_wr;
    logic w_in_pop;

    assign w_ram_wr  = w_wr & ~w_io;
    assign w_push    = w_wr & w_io & (w_off == c_off_out_data);
    assign w_stat_wr = w_wr & w_io & (w_off == c_off_out_stat);

    // Reading IN_DATA consumes the held word; an empty read has no effect.
    logic r_hold_valid;
    assign w_in_pop = w_rd & w_io & (w_off == c_off_in_data) & r_hold_valid;

    // Upper address half and byte-lane bits do not take part in decode.
    logic w_unused;
    assign w_unused = ^{bus.a_bus[31:16], bus.a_bus[1:0]};

    // ------------------------------------------------------------------
    // Data RAM (contents survive reset)
    // ------------------------------------------------------------------
    logic [31:0] r_ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            r_ram[w_ram_idx] <= bus.d_bus_2;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0] w_count;
    logic               w_full;
    logic               w_empty;
    logic [31:0]        w_head;

    io_out_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (32),
        .CNT_W (c_cnt_w)
    ) u_out_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (bus.d_bus_2),
        .i_pop       (bus.out_ready),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head)
    );

    // A push against a full FIFO is lost unless the head drains the same
    // cycle; the FIFO then still has room and takes it.
    logic w_reject;
    assign w_reject = w_push & w_full & ~bus.out_ready;

    logic r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_reject) begin
            r_overflow <= 1'b1;
        end else if (w_stat_wr) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.out_valid = ~w_empty;
    assign bus.out_data  = w_head;

    // ------------------------------------------------------------------
    // Input holding register
    // ------------------------------------------------------------------
    logic [31:0] r_hold_data;
    logic        w_in_load;

    // Load and pop are exclusive: loading needs the register empty and
    // popping needs it full.
    assign w_in_load = bus.in_valid & ~r_hold_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= 32'h0;
        end else if (w_in_pop) begin
            r_hold_valid <= 1'b0;
        end else if (w_in_load) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= bus.in_data;
        end
    end

    assign bus.in_ready = ~r_hold_valid;

    // ------------------------------------------------------------------
    // Combinational read mux
    // ------------------------------------------------------------------
    logic [31:0] w_rdata;
    logic [3:0]  w_count4;

    assign w_count4 = 4'(w_count);

    always_comb begin
        w_rdata = 32'h0;
        if (w_rd) begin
            if (w_io) begin
                case (w_off)
                    c_off_out_stat: w_rdata = out_stat_word(r_overflow, w_count4);
                    c_off_in_data:  w_rdata = r_hold_valid ? r_hold_data : 32'h0;
                    c_off_in_stat:  w_rdata = {31'b0, r_hold_valid};
                    default:        w_rdata = 32'h0;
                endcase
            end else begin
                w_rdata = r_ram[w_ram_idx];
            end
        end
    end

    always_comb begin
        bus.d_bus_1                = {2'b00, w_rdata};
        bus.d_bus_1[c_d1_hold_bit] = r_hold_valid;
        bus.d_bus_1[c_d1_full_bit] = w_full;
    end

endmodule : bus_io_bridge
`default_nettype wire

// File: tb/tb_bus_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_io_bridge
//  Description : Self-checking bench for bus_io_bridge. Directed steps follow
//                the bridge's intended use cases, then a randomized phase.
//                Expected values come from a queue/array model of the
//                memory map and FIFO behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_io_bridge;
    import bus_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_io_bridge_if bif ();

    bus_io_bridge #(
        .OUT_DEPTH (DEPTH),
        .RAM_WORDS (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] mq[$];
    bit          m_ovf;
    bit          m_hv;
    logic [31:0] m_hd;
    logic [31:0] m_ram [64];
    bit          m_known [64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_hv  = 1'b0;
        m_hd  = 32'h0;
    endtask

    function automatic logic [31:0] exp_rdata(input logic [1:0] c, input logic [31:0] a,
                                              output bit known);
        logic [3:0] cnt;
        known = 1'b1;
        cnt   = 4'(mq.size());
        if (c != 2'b01) return 32'h0;
        if (a[15:8] == 8'hFF) begin
            case (a[7:2])
                6'd1:    return {m_ovf, 27'b0, cnt};
                6'd2:    return m_hv ? m_hd : 32'h0;
                6'd3:    return {31'b0, m_hv};
                default: return 32'h0;
            endcase
        end
        known = m_known[a[7:2]];
        return m_ram[a[7:2]];
    endfunction

    // Apply a bus command and check every output against the model.
    task automatic drive(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                         input string tag);
        logic [31:0] er;
        bit          kn;
        bit          e_full;
        bit          e_val;
        bif.c_bus   = c;
        bif.a_bus   = a;
        bif.d_bus_2 = d;
        #2;
        er     = exp_rdata(c, a, kn);
        e_full = (mq.size() == DEPTH);
        e_val  = (mq.size() != 0);
        chk({tag, "/full"}, 64'(bif.d_bus_1[33]), 64'(e_full));
        chk({tag, "/hold"}, 64'(bif.d_bus_1[32]), 64'(m_hv));
        if (kn) chk({tag, "/rdata"}, 64'(bif.d_bus_1[31:0]), 64'(er));
        chk({tag, "/out_valid"}, 64'(bif.out_valid), 64'(e_val));
        if (e_val) chk({tag, "/out_data"}, 64'(bif.out_data), 64'(mq[0]));
        chk({tag, "/in_ready"}, 64'(bif.in_ready), 64'(!m_hv));
    endtask

    // Advance the model by one edge using the currently driven inputs.
    task automatic adv();
        logic [1:0]  c;
        logic [31:0] a;
        logic [31:0] d;
        bit          io;
        bit          pop;
        bit          was_full;
        logic [5:0]  w;
        c  = bif.c_bus;
        a  = bif.a_bus;
        d  = bif.d_bus_2;
        io = (a[15:8] == 8'hFF);
        w  = a[7:2];
        was_full = (mq.size() == DEPTH);
        pop      = bif.out_ready && (mq.size() > 0);
        if (pop) void'(mq.pop_front());
        if (c == 2'b10 && io && w == 6'd0) begin
            if (!was_full || pop) mq.push_back(d);
            else m_ovf = 1'b1;
        end
        if (c == 2'b10 && io && w == 6'd1) m_ovf = 1'b0;
        if (c == 2'b10 && !io) begin
            m_ram[w]   = d;
            m_known[w] = 1'b1;
        end
        if (c == 2'b01 && io && w == 6'd2 && m_hv) begin
            m_hv = 1'b0;
        end else if (bif.in_valid && !m_hv) begin
            m_hv = 1'b1;
            m_hd = bif.in_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                       input string tag);
        drive(c, a, d, tag);
        adv();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rd;
        logic [1:0]  rc;
        int          rsel;

        rst           = 1'b1;
        bif.a_bus     = 32'h0;
        bif.d_bus_2   = 32'h0;
        bif.c_bus     = 2'b00;
        bif.in_data   = 32'h0;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            m_known[i] = 1'b0;
            m_ram[i]   = 32'h0;
        end
        model_reset();

        // Reset state
        #2;
        chk("reset/out_valid", 64'(bif.out_valid), 64'h0);
        chk("reset/in_ready", 64'(bif.in_ready), 64'h1);
        chk("reset/d_bus_1", 64'(bif.d_bus_1), 64'h0);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        // RAM write then read
        cyc(CMD_WRITE, 32'h0000_0010, 32'hDEAD_BEEF, "ram_wr");
        drive(CMD_READ, 32'h0000_0010, 32'h0, "ram_rd");
        chk("ram_rd_word", 64'(bif.d_bus_1), 64'h0_DEAD_BEEF);
        adv();

        // Fill and overflow the output FIFO
        bif.out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc(CMD_WRITE, 32'h0000_FF00, 32'(k), "push");
            if (k == 4) begin
                drive(CMD_READ, 32'h0000_FF04, 32'h0, "stat4");
                chk("stat_full4", 64'(bif.d_bus_1), 64'h2_0000_0004);
                adv();
            end
        end
        drive(CMD_READ, 32'h0000_FF04, 32'h0, "stat_ovf");
        chk("stat_ovf", 64'(bif.d_bus_1), 64'h2_8000_0004);
        adv();
        cyc(CMD_WRITE, 32'h0000_FF04, 32'h0, "ovf_clr");
        drive(CMD_READ, 32'h0000_FF04, 32'h0, "stat_clr");
        chk("stat_clr", 64'(bif.d_bus_1), 64'h2_0000_0004);
        adv();

        // Drain 1..4
        bif.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_data", 64'(bif.out_data), 64'(k));
            chk("drain_valid", 64'(bif.out_valid), 64'h1);
            cyc(CMD_IDLE, 32'h0, 32'h0, "drain");
        end
        chk("drained_valid", 64'(bif.out_valid), 64'h0);
        drive(CMD_READ, 32'h0000_FF04, 32'h0, "stat_empty");
        chk("stat_empty", 64'(bif.d_bus_1), 64'h0);
        adv();

        // Push every cycle while full and draining
        bif.out_ready = 1'b0;
        for (int k = 11; k <= 14; k++) cyc(CMD_WRITE, 32'h0000_FF00, 32'(k), "prefill");
        bif.out_ready = 1'b1;
        for (int k = 20; k <= 29; k++) begin
            drive(CMD_WRITE, 32'h0000_FF00, 32'(k), "stream");
            chk("stream_full", 64'(bif.d_bus_1[33]), 64'h1);
            adv();
        end
        bif.out_ready = 1'b0;
        drive(CMD_READ, 32'h0000_FF04, 32'h0, "stream_stat");
        chk("stream_stat", 64'(bif.d_bus_1), 64'h2_0000_0004);
        adv();
        bif.out_ready = 1'b1;
        for (int k = 26; k <= 29; k++) begin
            chk("stream_order", 64'(bif.out_data), 64'(k));
            cyc(CMD_IDLE, 32'h0, 32'h0, "stream_drain");
        end
        chk("stream_done", 64'(bif.out_valid), 64'h0);
        bif.out_ready = 1'b0;

        // Input path
        bif.in_data  = 32'h0000_1234;
        bif.in_valid = 1'b1;
        cyc(CMD_IDLE, 32'h0, 32'h0, "in_offer");
        bif.in_valid = 1'b0;
        drive(CMD_IDLE, 32'h0, 32'h0, "in_held");
        chk("in_held_ready", 64'(bif.in_ready), 64'h0);
        chk("in_held_flag", 64'(bif.d_bus_1[32]), 64'h1);
        adv();
        drive(CMD_READ, 32'h0000_FF08, 32'h0, "in_pop");
        chk("in_pop_data", 64'(bif.d_bus_1[31:0]), 64'h1234);
        adv();
        drive(CMD_READ, 32'h0000_FF0C, 32'h0, "in_stat");
        chk("in_stat_zero", 64'(bif.d_bus_1), 64'h0);
        chk("in_ready_back", 64'(bif.in_ready), 64'h1);
        adv();
        drive(CMD_READ, 32'h0000_FF08, 32'h0, "in_empty");
        chk("in_empty_read", 64'(bif.d_bus_1), 64'h0);
        adv();

        // Mid-cycle reset with pending FIFO data and a held input
        cyc(CMD_WRITE, 32'h0000_FF00, 32'h0000_00A1, "pre_rst_push");
        cyc(CMD_WRITE, 32'h0000_FF00, 32'h0000_00A2, "pre_rst_push");
        bif.in_data  = 32'h0000_0055;
        bif.in_valid = 1'b1;
        cyc(CMD_IDLE, 32'h0, 32'h0, "pre_rst_in");
        bif.in_valid = 1'b0;
        chk("pre_rst_valid", 64'(bif.out_valid), 64'h1);
        chk("pre_rst_ready", 64'(bif.in_ready), 64'h0);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(bif.out_valid), 64'h0);
        chk("rst_in_ready", 64'(bif.in_ready), 64'h1);
        chk("rst_flags", 64'(bif.d_bus_1[33:32]), 64'h0);
        model_reset();
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        drive(CMD_READ, 32'h0000_FF04, 32'h0, "post_rst_stat");
        chk("post_rst_stat", 64'(bif.d_bus_1), 64'h0);
        adv();
        chk("post_rst_ram", 64'(m_known[4]), 64'h1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            ra   = $urandom();
            rd   = $urandom();
            rc   = 2'($urandom_range(0, 3));
            rsel = $urandom_range(0, 9);
            if (rsel < 5) begin
                ra[15:8] = 8'($urandom_range(0, 254));
                ra[7:2]  = 6'($urandom_range(0, 15));
            end else begin
                ra[15:8] = 8'hFF;
                ra[7:2]  = 6'($urandom_range(0, 5));
            end
            bif.in_valid  = ($urandom_range(0, 2) == 0);
            bif.in_data   = $urandom();
            bif.out_ready = ($urandom_range(0, 1) == 1);
            cyc(rc, ra, rd, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_bus_io_bridge
`default_nettype wire
